// File: rtl/field_storage.sv
// Double-buffered Game-of-Life field store: combinational toroidal neighbourhood lookup,
// iterator write into the opposite field, pattern load, row-sweep clear and display read.
module field_storage #(
   parameter int FIELD_W = 64,
   parameter int FIELD_H = 48,
   localparam int X_ADR_SIZE = $clog2(FIELD_W),
   localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_read_field,
   input  logic                  i_sim_active,
   input  logic [X_ADR_SIZE-1:0] i_next_x,
   input  logic [Y_ADR_SIZE-1:0] i_next_y,
   output logic                  o_next_cell,
   output logic [7:0]            o_next_nbrs,
   input  logic [X_ADR_SIZE-1:0] i_wr_x,
   input  logic [Y_ADR_SIZE-1:0] i_wr_y,
   input  logic                  i_wr_cell,
   input  logic                  i_ld_valid,
   input  logic [X_ADR_SIZE-1:0] i_ld_x,
   input  logic [Y_ADR_SIZE-1:0] i_ld_y,
   input  logic                  i_ld_val,
   output logic                  o_ld_ready,
   input  logic                  i_clear,
   output logic                  o_busy,
   input  logic [X_ADR_SIZE-1:0] i_disp_x,
   input  logic [Y_ADR_SIZE-1:0] i_disp_y,
   output logic                  o_disp_cell
);

   localparam logic FIELD_A = 1'b0;
   localparam int XN = 1 << X_ADR_SIZE;
   localparam int YN = 1 << Y_ADR_SIZE;
   // Per-address in-range masks, so range checks never compare against unreachable constants
   localparam logic [XN-1:0] X_OK = {XN{1'b1}} >> (XN - FIELD_W);
   localparam logic [YN-1:0] Y_OK = {YN{1'b1}} >> (YN - FIELD_H);
   localparam logic [X_ADR_SIZE-1:0] X_MAX = X_ADR_SIZE'(FIELD_W - 1);
   localparam logic [Y_ADR_SIZE-1:0] Y_MAX = Y_ADR_SIZE'(FIELD_H - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                state, state_nxt;
   logic [Y_ADR_SIZE-1:0] row_cnt;
   logic [FIELD_W-1:0]    field_a [FIELD_H];
   logic [FIELD_W-1:0]    field_b [FIELD_H];

   logic                  nb_ok;
   logic [Y_ADR_SIZE-1:0] y_idx, ym, yp;
   logic [X_ADR_SIZE-1:0] xm, xp;
   logic [FIELD_W-1:0]    row_m, row_c, row_p;
   logic                  disp_ok;
   logic [Y_ADR_SIZE-1:0] disp_y_idx;
   logic [FIELD_W-1:0]    disp_row;
   logic                  wr_en, ld_en;

   // Neighbourhood lookup
   assign nb_ok = X_OK[i_next_x] & Y_OK[i_next_y];
   assign y_idx = Y_OK[i_next_y] ? i_next_y : '0;
   assign ym    = (y_idx == '0)    ? Y_MAX : y_idx - 1'b1;
   assign yp    = (y_idx == Y_MAX) ? '0    : y_idx + 1'b1;
   assign xm    = (i_next_x == '0)    ? X_MAX : i_next_x - 1'b1;
   assign xp    = (i_next_x == X_MAX) ? '0    : i_next_x + 1'b1;

   always_comb begin
      row_m = '0;
      row_c = '0;
      row_p = '0;
      if (i_read_field == FIELD_A) begin
         row_m = field_a[ym];
         row_c = field_a[y_idx];
         row_p = field_a[yp];
      end else begin
         row_m = field_b[ym];
         row_c = field_b[y_idx];
         row_p = field_b[yp];
      end
   end

   assign o_next_cell = nb_ok & row_c[i_next_x];
   assign o_next_nbrs = nb_ok ? {row_p[xp], row_p[i_next_x], row_p[xm],
                                 row_c[xp], row_c[xm],
                                 row_m[xp], row_m[i_next_x], row_m[xm]} : 8'h00;

   // Display read
   assign disp_ok    = X_OK[i_disp_x] & Y_OK[i_disp_y];
   assign disp_y_idx = Y_OK[i_disp_y] ? i_disp_y : '0;
   assign disp_row   = (i_read_field == FIELD_A) ? field_a[disp_y_idx] : field_b[disp_y_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) o_disp_cell <= 1'b0;
      else        o_disp_cell <= disp_ok & disp_row[i_disp_x];
   end

   // Write, load and clear ports
   assign o_busy     = (state == CLEAR);
   assign o_ld_ready = rst_n & (state == IDLE) & ~i_sim_active & ~i_clear;
   assign wr_en      = i_sim_active & X_OK[i_wr_x] & Y_OK[i_wr_y];
   assign ld_en      = i_ld_valid & o_ld_ready & X_OK[i_ld_x] & Y_OK[i_ld_y];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < FIELD_H; r++) begin
            field_a[r] <= '0;
            field_b[r] <= '0;
         end
      end else begin
         if (wr_en) begin
            if (i_read_field == FIELD_A) field_b[i_wr_y][i_wr_x] <= i_wr_cell;
            else                         field_a[i_wr_y][i_wr_x] <= i_wr_cell;
         end
         if (ld_en) begin
            if (i_read_field == FIELD_A) field_a[i_ld_y][i_ld_x] <= i_ld_val;
            else                         field_b[i_ld_y][i_ld_x] <= i_ld_val;
         end
         // Clearing overrides any iterator write landing on the same row
         if (state == CLEAR) begin
            field_a[row_cnt] <= '0;
            field_b[row_cnt] <= '0;
         end
      end
   end

   // Clear sweep FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         row_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) row_cnt <= (row_cnt == Y_MAX) ? '0 : row_cnt + 1'b1;
         else                row_cnt <= '0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_clear && !i_sim_active) state_nxt = CLEAR;
         CLEAR:   if (row_cnt == Y_MAX) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_field_storage.sv
// Bench for field_storage: randomized load/write/lookup/display traffic against an array model.
module tb_field_storage;
   localparam int W = 64;
   localparam int H = 48;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       read_field, sim_active;
   logic [5:0] next_x, next_y, wr_x, wr_y, ld_x, ld_y, disp_x, disp_y;
   logic       next_cell, wr_cell, ld_valid, ld_val, ld_ready, clear, busy, disp_cell;
   logic [7:0] next_nbrs;

   int  errors = 0;
   int  checks = 0;
   bit  mdl [2][H][W];

   field_storage #(.FIELD_W(W), .FIELD_H(H)) dut (
      .clk(clk), .rst_n(rst_n), .i_read_field(read_field), .i_sim_active(sim_active),
      .i_next_x(next_x), .i_next_y(next_y), .o_next_cell(next_cell), .o_next_nbrs(next_nbrs),
      .i_wr_x(wr_x), .i_wr_y(wr_y), .i_wr_cell(wr_cell),
      .i_ld_valid(ld_valid), .i_ld_x(ld_x), .i_ld_y(ld_y), .i_ld_val(ld_val), .o_ld_ready(ld_ready),
      .i_clear(clear), .o_busy(busy),
      .i_disp_x(disp_x), .i_disp_y(disp_y), .o_disp_cell(disp_cell)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic exp_cell(int f, int x, int y);
      if (x >= W || y >= H) return 1'b0;
      return mdl[f][y][x];
   endfunction

   // Neighbours in row-major order around (x,y), skipping the centre, on a torus
   function automatic logic [7:0] exp_nbrs(int f, int x, int y);
      logic [7:0] r;
      int k;
      r = '0;
      k = 0;
      if (x >= W || y >= H) return 8'h00;
      for (int dy = -1; dy <= 1; dy++)
         for (int dx = -1; dx <= 1; dx++)
            if (dx != 0 || dy != 0) begin
               r[k] = mdl[f][(y + dy + H) % H][(x + dx + W) % W];
               k++;
            end
      return r;
   endfunction

   function automatic int rand_x();
      return ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(60, 63);
   endfunction

   function automatic int rand_y();
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) return r;
      if (r < 8) return 40 + r;
      return $urandom_range(48, 63);
   endfunction

   task automatic zero_model();
      for (int f = 0; f < 2; f++)
         for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) mdl[f][y][x] = 1'b0;
   endtask

   task automatic idle_inputs();
      read_field = 1'b0; sim_active = 1'b0;
      next_x = '0; next_y = '0; wr_x = '0; wr_y = '0; wr_cell = 1'b0;
      ld_valid = 1'b0; ld_x = '0; ld_y = '0; ld_val = 1'b0;
      clear = 1'b0; disp_x = '0; disp_y = '0;
   endtask

   // Called at a negedge; the load is presented across one posedge
   task automatic drive_load(input int f, input int x, input int y, input bit v);
      read_field = f[0];
      ld_valid = 1'b1; ld_x = 6'(x); ld_y = 6'(y); ld_val = v;
      @(negedge clk);
      ld_valid = 1'b0;
      if (x < W && y < H) mdl[f][y][x] = v;
   endtask

   task automatic test_reset();
      idle_inputs();
      zero_model();
      rst_n = 1'b0;
      #2;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (disp_cell !== 1'b0) begin errors++; $display("FAIL reset_disp got %b exp 0", disp_cell); end
      checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready got %b exp 0", ld_ready); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ld_ready got %b exp 1", ld_ready); end
   endtask

   // Compares every cell and neighbourhood of both fields with the model
   task automatic test_field_contents(input string tag);
      @(negedge clk);
      for (int f = 0; f < 2; f++) begin
         read_field = f[0];
         for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
               next_x = 6'(x); next_y = 6'(y);
               #1;
               checks++;
               if (next_cell !== exp_cell(f, x, y)) begin
                  errors++;
                  $display("FAIL %s cell f=%0d (%0d,%0d) got %b exp %b", tag, f, x, y, next_cell, exp_cell(f, x, y));
               end
               checks++;
               if (next_nbrs !== exp_nbrs(f, x, y)) begin
                  errors++;
                  $display("FAIL %s nbrs f=%0d (%0d,%0d) got %h exp %h", tag, f, x, y, next_nbrs, exp_nbrs(f, x, y));
               end
            end
      end
      read_field = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_load_pattern();
      @(negedge clk);
      drive_load(0, 1, 0, 1'b1);
      drive_load(0, 1, 1, 1'b1);
      drive_load(0, 1, 2, 1'b1);
      read_field = 1'b0; next_x = 6'd0; next_y = 6'd1;
      #1;
      checks++; if (next_nbrs !== exp_nbrs(0, 0, 1)) begin errors++; $display("FAIL pattern_nbrs got %h exp %h", next_nbrs, exp_nbrs(0, 0, 1)); end
      checks++; if (next_nbrs !== 8'h94) begin errors++; $display("FAIL pattern_nbrs_abs got %h exp 94", next_nbrs); end
      checks++; if (next_cell !== 1'b0) begin errors++; $display("FAIL pattern_cell got %b exp 0", next_cell); end
      read_field = 1'b1;
      #1;
      checks++; if (next_nbrs !== 8'h00) begin errors++; $display("FAIL pattern_other_field got %h exp 00", next_nbrs); end
   endtask

   task automatic test_corner();
      @(negedge clk);
      drive_load(0, W - 1, H - 1, 1'b1);
      read_field = 1'b0; next_x = 6'd0; next_y = 6'd0;
      #1;
      checks++; if (next_nbrs[0] !== 1'b1) begin errors++; $display("FAIL corner_bit0 got %b exp 1", next_nbrs[0]); end
      checks++; if (next_nbrs !== exp_nbrs(0, 0, 0)) begin errors++; $display("FAIL corner_nbrs got %h exp %h", next_nbrs, exp_nbrs(0, 0, 0)); end
      next_x = 6'(W - 2); next_y = 6'(H - 2);
      #1;
      checks++; if (next_nbrs !== exp_nbrs(0, W - 2, H - 2)) begin errors++; $display("FAIL corner_inner got %h exp %h", next_nbrs, exp_nbrs(0, W - 2, H - 2)); end
   endtask

   // The iterator flips the read field on the same edge as its last write
   task automatic test_write_flip();
      @(negedge clk);
      read_field = 1'b0; sim_active = 1'b1;
      wr_x = 6'd3; wr_y = 6'd4; wr_cell = 1'b1;
      @(posedge clk);
      #1;
      read_field = 1'b1; sim_active = 1'b0;
      mdl[1][4][3] = 1'b1;
      @(negedge clk);
      next_x = 6'd3; next_y = 6'd4;
      #1;
      checks++; if (next_cell !== 1'b1) begin errors++; $display("FAIL write_b_cell got %b exp 1", next_cell); end
      read_field = 1'b0;
      #1;
      checks++; if (next_cell !== exp_cell(0, 3, 4)) begin errors++; $display("FAIL write_a_unchanged got %b exp %b", next_cell, exp_cell(0, 3, 4)); end
   endtask

   task automatic test_random();
      int op, f, x, y;
      bit v;
      @(negedge clk);
      for (int i = 0; i < 500; i++) begin
         op = $urandom_range(0, 5);
         f  = $urandom_range(0, 1);
         x  = rand_x();
         y  = rand_y();
         v  = 1'($urandom_range(0, 1));
         read_field = f[0];
         case (op)
            0, 1: begin
               #1;
               checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL rnd_ld_ready got %b exp 1", ld_ready); end
               drive_load(f, x, y, v);
            end
            2: begin
               sim_active = 1'b1; wr_x = 6'(x); wr_y = 6'(y); wr_cell = v;
               @(negedge clk);
               sim_active = 1'b0;
               if (x < W && y < H) mdl[1 - f][y][x] = v;
            end
            3, 4: begin
               next_x = 6'(x); next_y = 6'(y);
               #1;
               checks++; if (next_cell !== exp_cell(f, x, y)) begin errors++; $display("FAIL rnd_cell f=%0d (%0d,%0d) got %b exp %b", f, x, y, next_cell, exp_cell(f, x, y)); end
               checks++; if (next_nbrs !== exp_nbrs(f, x, y)) begin errors++; $display("FAIL rnd_nbrs f=%0d (%0d,%0d) got %h exp %h", f, x, y, next_nbrs, exp_nbrs(f, x, y)); end
               @(negedge clk);
            end
            default: begin
               disp_x = 6'(x); disp_y = 6'(y);
               @(negedge clk);
               checks++; if (disp_cell !== exp_cell(f, x, y)) begin errors++; $display("FAIL rnd_disp f=%0d (%0d,%0d) got %b exp %b", f, x, y, disp_cell, exp_cell(f, x, y)); end
            end
         endcase
      end
   endtask

   task automatic test_clear();
      int n;
      @(negedge clk);
      for (int i = 0; i < 6; i++) drive_load(i % 2, $urandom_range(0, W - 1), $urandom_range(0, H - 1), 1'b1);
      drive_load(1, 0, H - 1, 1'b1);
      read_field = 1'b0;
      clear = 1'b1; ld_valid = 1'b1; ld_x = 6'd2; ld_y = 6'd2; ld_val = 1'b1;
      #1;
      checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL clear_vs_load_ready got %b exp 0", ld_ready); end
      @(negedge clk);
      clear = 1'b0; ld_valid = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL clear_ld_ready cycle %0d got %b exp 0", n, ld_ready); end
         n++;
         clear = (n == 10);
         @(negedge clk);
      end
      clear = 1'b0;
      checks++; if (n != H) begin errors++; $display("FAIL clear_busy_cycles got %0d exp %0d", n, H); end
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_no_restart got %b exp 0", busy); end
      zero_model();
   endtask

   task automatic test_reset_mid_clear();
      @(negedge clk);
      for (int i = 0; i < 6; i++) drive_load(i % 2, $urandom_range(0, W - 1), $urandom_range(0, H - 1), 1'b1);
      drive_load(0, 5, H - 1, 1'b1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midclear_busy_before got %b exp 1", busy); end
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midclear_busy_after got %b exp 0", busy); end
      checks++; if (disp_cell !== 1'b0) begin errors++; $display("FAIL midclear_disp got %b exp 0", disp_cell); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midclear_busy_next got %b exp 0", busy); end
      rst_n = 1'b1;
      zero_model();
   endtask

   task automatic test_clear_while_sim();
      @(negedge clk);
      read_field = 1'b0; sim_active = 1'b1; wr_x = 6'd7; wr_y = 6'd7; wr_cell = 1'b1;
      clear = 1'b1;
      #1;
      checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL sim_ld_ready got %b exp 0", ld_ready); end
      @(negedge clk);
      clear = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sim_clear_busy cycle %0d got %b exp 0", i, busy); end
         @(negedge clk);
      end
      sim_active = 1'b0;
      mdl[1][7][7] = 1'b1;
      read_field = 1'b1; next_x = 6'd7; next_y = 6'd7;
      #1;
      checks++; if (next_cell !== 1'b1) begin errors++; $display("FAIL sim_clear_write_kept got %b exp 1", next_cell); end
   endtask

   initial begin
      test_reset();
      test_field_contents("after_reset");
      test_load_pattern();
      test_corner();
      test_write_flip();
      test_random();
      test_field_contents("after_random");
      test_clear();
      test_field_contents("after_clear");
      test_reset_mid_clear();
      test_field_contents("after_midclear_reset");
      test_clear_while_sim();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
